// File: rtl/truth_table_extractor_if.sv
// Term stream between the extractor and its consumer: one index per handshake.
interface truth_table_extractor_if #(parameter int N = 4);
    logic         term_valid;
    logic         term_ready;
    logic [N-1:0] term_index;

    modport master (output term_valid, output term_index, input term_ready);
    modport slave  (input term_valid, input term_index, output term_ready);
endinterface

// File: rtl/truth_table_extractor.sv
// Sweeps all 2^N FUT inputs, captures the truth table, then streams minterm/maxterm indices.
// Latency 1+2^N+2^N cycles start-to-done plus consumer stalls; term stream holds under backpressure.
module truth_table_extractor #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sel_pos,
    output logic [N-1:0]        fut_in,
    input  logic                fut_out,
    output logic [(1<<N)-1:0]   mask,
    output logic [N:0]          ones_count,
    output logic                busy,
    output logic                done,
    truth_table_extractor_if.master term
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

    state_t       state, state_nxt;
    logic [N-1:0] idx;
    logic [N-1:0] ptr;
    logic         sel_q;
    logic         match;
    logic         adv;

    // fut_in is the scan counter itself, so the FUT sees idx in the very cycle it is captured
    assign fut_in = idx;

    always_comb begin
        match           = (mask[ptr] != sel_q);
        adv             = (!match) || term.term_ready;
        state_nxt       = state;
        busy            = 1'b0;
        done            = 1'b0;
        term.term_valid = 1'b0;
        term.term_index = ptr;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (idx == {N{1'b1}}) state_nxt = S_EMIT;
            end
            S_EMIT: begin
                busy            = 1'b1;
                term.term_valid = match;
                if (adv && (ptr == {N{1'b1}})) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            ptr        <= '0;
            sel_q      <= 1'b0;
            mask       <= '0;
            ones_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel_q      <= sel_pos;
                        mask       <= '0;
                        ones_count <= '0;
                        idx        <= '0;
                        ptr        <= '0;
                    end
                end
                S_SCAN: begin
                    mask[idx]  <= fut_out;
                    ones_count <= ones_count + {{N{1'b0}}, fut_out};
                    // wraps back to 0 after the last input, leaving fut_in at its idle value
                    idx        <= idx + 1'b1;
                end
                S_EMIT: begin
                    if (adv) ptr <= ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
